// File: rtl/seven_seg_scan_rx.sv
// Receiver for a multiplexed 7-segment scan bus.
// It samples the bus and locks onto the 0..7 scan order. Each scanned digit is
// demultiplexed into a working buffer. A complete frame is published to oSEG/oBCD/oBAD
// in one step, so the outputs never show a partly captured frame.
//
// Ports:
//   iCLK    clock, rising edge
//   nRST    synchronous reset, active-high
//   iS_COM  active-low digit select, bit k = digit k (8'hFF = blank)
//   iS_ENS  segment pattern a..g (bit6 = a, bit0 = g)
//   oSEG    last complete frame, digit k at [7k+6:7k]
//   oBCD    decoded digits, digit k at [4k+3:4k], 4'hF = not a 0-9 pattern
//   oBAD    bit k set when oSEG digit k is not a 0-9 pattern
//   oLOCK   high while locked to the scan order
//   oFRAME  1-cycle pulse when a new frame is published
//   oERR    1-cycle pulse on loss of sync
module seven_seg_scan_rx #(
   parameter int unsigned STABLE_CYC = 1,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        iCLK,
   input  logic        nRST,
   input  logic [7:0]  iS_COM,
   input  logic [6:0]  iS_ENS,
   output logic [55:0] oSEG,
   output logic [31:0] oBCD,
   output logic [7:0]  oBAD,
   output logic        oLOCK,
   output logic        oFRAME,
   output logic        oERR
);

   localparam int unsigned RunW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
   localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
   localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYC);

   typedef enum logic {StHunt, StSync} state_e;

   state_e            state_q, state_d;
   logic [7:0]        com_q, prev_com_q;
   logic [6:0]        ens_q, prev_ens_q;
   logic [RunW-1:0]   run_q, run_d;
   logic [ToW-1:0]    to_q, to_d, to_inc;
   logic [2:0]        exp_q, exp_d;
   logic [7:0][6:0]   work_q, work_d;
   logic [55:0]       seg_q, seg_d;
   logic [31:0]       bcd_q, bcd_d;
   logic [7:0]        bad_q, bad_d;
   logic              frame_q, frame_d;
   logic              err_q, err_d;

   logic [3:0]        zeros;
   logic [2:0]        dig;
   logic              is_blank, is_digit, is_illegal, same, capture;
   logic [4:0]        dec;

   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = {1'b0, 4'd0};
         7'h30:   r = {1'b0, 4'd1};
         7'h6D:   r = {1'b0, 4'd2};
         7'h79:   r = {1'b0, 4'd3};
         7'h33:   r = {1'b0, 4'd4};
         7'h5B:   r = {1'b0, 4'd5};
         7'h5F:   r = {1'b0, 4'd6};
         7'h72:   r = {1'b0, 4'd7};
         7'h7F:   r = {1'b0, 4'd8};
         7'h7B:   r = {1'b0, 4'd9};
         default: r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   // COM classification: count active (low) select lines.
   always_comb begin
      zeros = '0;
      dig   = '0;
      for (int k = 0; k < 8; k++) begin
         if (!com_q[k]) begin
            zeros = zeros + 4'd1;
            dig   = 3'(k);
         end
      end
   end

   assign is_blank   = (com_q == 8'hFF);
   assign is_digit   = (zeros == 4'd1);
   assign is_illegal = !is_blank && !is_digit;
   assign same       = ({com_q, ens_q} == {prev_com_q, prev_ens_q});

   // Dwell counter saturates at RunMax; capture only on the cycle it first gets there.
   always_comb begin
      run_d = run_q;
      if (is_blank) begin
         run_d = '0;
      end else if (same) begin
         if (run_q != RunMax) run_d = run_q + RunW'(1);
      end else begin
         run_d = RunW'(1);
      end
   end

   assign capture = is_digit && (run_d == RunMax) && (!same || (run_q != RunMax));
   assign to_inc  = to_q + ToW'(1);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      work_d  = work_q;
      to_d    = to_q;
      seg_d   = seg_q;
      bcd_d   = bcd_q;
      bad_d   = bad_q;
      frame_d = 1'b0;
      err_d   = 1'b0;
      dec     = '0;
      unique case (state_q)
         StHunt: begin
            to_d = '0;
            if (capture && (dig == 3'd0)) begin
               state_d   = StSync;
               exp_d     = 3'd1;
               work_d[0] = ens_q;
            end
         end
         StSync: begin
            if (is_illegal) begin
               err_d   = 1'b1;
               state_d = StHunt;
               to_d    = '0;
            end else if (capture) begin
               // A capture always clears the timeout, so it wins over a same-cycle expiry.
               to_d = '0;
               if (dig == exp_q) begin
                  work_d[dig] = ens_q;
                  exp_d       = exp_q + 3'd1;
                  if (dig == 3'd7) begin
                     seg_d   = work_d;
                     frame_d = 1'b1;
                     for (int k = 0; k < 8; k++) begin
                        dec            = decode(work_d[k]);
                        bcd_d[4*k +: 4] = dec[3:0];
                        bad_d[k]        = dec[4];
                     end
                  end
               end else begin
                  err_d = 1'b1;
                  if (dig == 3'd0) begin
                     // Out-of-order digit 0 starts a fresh frame without losing lock.
                     exp_d     = 3'd1;
                     work_d    = '0;
                     work_d[0] = ens_q;
                  end else begin
                     state_d = StHunt;
                  end
               end
            end else if (to_inc == ToW'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = StHunt;
               to_d    = '0;
            end else begin
               to_d = to_inc;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (nRST) begin
         state_q    <= StHunt;
         com_q      <= 8'hFF;
         ens_q      <= 7'h00;
         prev_com_q <= 8'hFF;
         prev_ens_q <= 7'h00;
         run_q      <= '0;
         to_q       <= '0;
         exp_q      <= '0;
         work_q     <= '0;
         seg_q      <= '0;
         bcd_q      <= '0;
         bad_q      <= '0;
         frame_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         com_q      <= iS_COM;
         ens_q      <= iS_ENS;
         prev_com_q <= com_q;
         prev_ens_q <= ens_q;
         run_q      <= run_d;
         to_q       <= to_d;
         exp_q      <= exp_d;
         work_q     <= work_d;
         seg_q      <= seg_d;
         bcd_q      <= bcd_d;
         bad_q      <= bad_d;
         frame_q    <= frame_d;
         err_q      <= err_d;
      end
   end

   assign oSEG   = seg_q;
   assign oBCD   = bcd_q;
   assign oBAD   = bad_q;
   assign oLOCK  = (state_q == StSync);
   assign oFRAME = frame_q;
   assign oERR   = err_q;

endmodule
